nand_avalon_csr_slave: RTL and testbench

//  Avalon-MM slave front-end: host-side responder for the NAND controller register map.

---
 rtl/nand_avalon_csr_slave_pkg.sv | 53 +++++
 rtl/nand_avalon_csr_slave_if.sv | 14 +
 rtl/nand_avalon_csr_slave_fifo.sv | 53 +++++
 rtl/nand_avalon_csr_slave.sv | 175 +++++++++++++++++
 tb/tb_nand_avalon_csr_slave.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nand_avalon_csr_slave_pkg.sv
// Register map, command opcodes and STATUS bit positions shared by the NAND CSR slave.
package nand_avalon_pkg;

  localparam int AVS_ADDR_W = 2;
  localparam int AVS_DATA_W = 32;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  localparam logic [7:0] CMD_NOP                  = 8'h00;
  localparam logic [7:0] CMD_RESET                = 8'h01;
  localparam logic [7:0] CMD_READ_PAGE            = 8'h02;
  localparam logic [7:0] CMD_READ_PAGE_CACHE      = 8'h03;
  localparam logic [7:0] CMD_READ_PAGE_CACHE_LAST = 8'h04;
  localparam logic [7:0] CMD_PROGRAM_PAGE         = 8'h05;
  localparam logic [7:0] CMD_PROGRAM_PAGE_CACHE   = 8'h06;
  localparam logic [7:0] CMD_ERASE_BLOCK          = 8'h07;
  localparam logic [7:0] CMD_READ_STATUS          = 8'h08;
  localparam logic [7:0] CMD_READ_ID              = 8'h09;
  localparam logic [7:0] CMD_READ_PARAM           = 8'h0A;
  localparam logic [7:0] CMD_GET_FEATURES         = 8'h0B;
  localparam logic [7:0] CMD_SET_FEATURES         = 8'h0C;
  localparam logic [7:0] CMD_READ_UNIQUE_ID       = 8'h0D;
  localparam logic [7:0] CMD_CHANGE_READ_COL      = 8'h0E;
  localparam logic [7:0] CMD_CHANGE_WRITE_COL     = 8'h0F;
  localparam logic [7:0] CMD_COPYBACK_READ        = 8'h10;
  localparam logic [7:0] CMD_COPYBACK_PROGRAM     = 8'h11;
  localparam logic [7:0] CMD_READ_STATUS_ENH      = 8'h12;
  localparam logic [7:0] CMD_SYNC_RESET           = 8'h13;
  localparam logic [7:0] CMD_LUN_RESET            = 8'h14;
  localparam logic [7:0] CMD_VOLUME_SELECT        = 8'h15;
  localparam logic [7:0] CMD_ODT_CONFIGURE        = 8'h16;
  localparam logic [7:0] CMD_ZQ_CAL_SHORT         = 8'h17;
  localparam logic [7:0] CMD_ZQ_CAL_LONG          = 8'h18;
  localparam logic [7:0] CMD_READ_RETRY           = 8'h19;
  localparam logic [7:0] CMD_LAST                 = CMD_READ_RETRY;

  localparam int ST_BUSY      = 0;
  localparam int ST_RNB       = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVF    = 4;
  localparam int ST_RX_UNF    = 5;
  localparam int ST_CMD_REJ   = 6;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;

  localparam int IRQ_IE   = 0;
  localparam int IRQ_DONE = 1;

endpackage

// File: rtl/nand_avalon_csr_slave_if.sv
// Avalon-MM register bus between the host master and the NAND CSR slave.
interface nand_avalon_csr_slave_if;
  import nand_avalon_pkg::*;

  logic [AVS_ADDR_W-1:0] addr;
  logic                  rd;
  logic                  wr;
  logic [AVS_DATA_W-1:0] wrdata;
  logic [AVS_DATA_W-1:0] rddata;

  modport master (output addr, rd, wr, wrdata, input rddata);
  modport slave  (input addr, rd, wr, wrdata, output rddata);

endinterface

// File: rtl/nand_avalon_csr_slave_fifo.sv
// nand_byte_fifo: synchronous byte FIFO for the RX path; a pop frees room for a same-cycle push.
module nand_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [7:0]             i_data,
  input  logic                   i_pop,
  output logic [7:0]             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign w_pop_ok    = i_pop & ~o_empty;
  assign w_push_ok   = i_push & (~o_full | w_pop_ok);
  assign o_overflow  = i_push & ~w_push_ok;
  assign o_underflow = i_pop & o_empty;
  assign o_head      = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_count     = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/nand_avalon_csr_slave.sv
// Avalon-MM CSR front-end for the NAND controller core: command handshake, TX bytes, RX FIFO, RnB sync.
// Optional interrupt register at addr 3 is built only when NAND_CSR_IRQ_EN is defined.
module nand_avalon_csr_slave
  import nand_avalon_pkg::*;
#(
  parameter int RX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  nand_avalon_csr_slave_if.slave        avs,
  output logic                          o_cmd_valid,
  output logic [7:0]                    o_cmd_code,
  input  logic                          i_cmd_ready,
  output logic                          o_tx_valid,
  output logic [7:0]                    o_tx_data,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_core_busy,
  input  logic                          i_core_done,
  input  logic                          i_nand_rnb,
  output logic                          o_irq
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic [AVS_DATA_W-1:0]  r_rddata;
  logic [AVS_DATA_W-1:0]  w_rd_mux;
  logic [AVS_DATA_W-1:0]  w_irq_rd;
  logic [15:0]            w_status;
  logic                   r_cmd_valid;
  logic [7:0]             r_cmd_code;
  logic                   r_tx_valid;
  logic [7:0]             r_tx_data;
  logic                   r_rx_ovf;
  logic                   r_rx_unf;
  logic                   r_cmd_rej;
  logic [SYNC_STAGES-1:0] r_rnb_sync;
  logic                   w_rnb;
  logic                   w_rd_data;
  logic                   w_wr_data;
  logic                   w_wr_cmd;
  logic                   w_wr_status;
  logic                   w_wr_irq;
  logic                   w_cmd_rej;
  logic [7:0]             w_rx_head;
  logic                   w_rx_full;
  logic                   w_rx_empty;
  logic [CW-1:0]          w_rx_count;
  logic                   w_rx_ovf_set;
  logic                   w_rx_unf_set;
  logic                   w_unused;

  assign w_rd_data   = avs.rd & (avs.addr == REG_DATA);
  assign w_wr_data   = avs.wr & (avs.addr == REG_DATA);
  assign w_wr_cmd    = avs.wr & (avs.addr == REG_CMD);
  assign w_wr_status = avs.wr & (avs.addr == REG_STATUS);
  assign w_wr_irq    = avs.wr & (avs.addr == REG_IRQ);

  nand_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_rx_valid),
    .i_data      (i_rx_data),
    .i_pop       (w_rd_data),
    .o_head      (w_rx_head),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_count     (w_rx_count),
    .o_overflow  (w_rx_ovf_set),
    .o_underflow (w_rx_unf_set)
  );

  // A write that lands while a command is still pending is refused, even on the accept edge.
  assign w_cmd_rej = w_wr_cmd & r_cmd_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 8'h00;
    end else if (r_cmd_valid && i_cmd_ready) begin
      r_cmd_valid <= 1'b0;
    end else if (w_wr_cmd && !r_cmd_valid) begin
      r_cmd_valid <= 1'b1;
      r_cmd_code  <= avs.wrdata[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_valid <= w_wr_data;
      if (w_wr_data) r_tx_data <= avs.wrdata[7:0];
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
      r_cmd_rej <= 1'b0;
    end else begin
      r_rx_ovf  <= w_rx_ovf_set | (r_rx_ovf  & ~(w_wr_status & avs.wrdata[ST_RX_OVF]));
      r_rx_unf  <= w_rx_unf_set | (r_rx_unf  & ~(w_wr_status & avs.wrdata[ST_RX_UNF]));
      r_cmd_rej <= w_cmd_rej    | (r_cmd_rej & ~(w_wr_status & avs.wrdata[ST_CMD_REJ]));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rnb_sync <= '0;
    else          r_rnb_sync <= {r_rnb_sync[SYNC_STAGES-2:0], i_nand_rnb};
  end
  assign w_rnb = r_rnb_sync[SYNC_STAGES-1];

`ifdef NAND_CSR_IRQ_EN
  logic r_irq_ie;
  logic r_irq_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_ie   <= 1'b0;
      r_irq_done <= 1'b0;
    end else begin
      if (w_wr_irq) r_irq_ie <= avs.wrdata[IRQ_IE];
      r_irq_done <= i_core_done | (r_irq_done & ~(w_wr_irq & avs.wrdata[IRQ_DONE]));
    end
  end

  assign o_irq    = r_irq_done & r_irq_ie;
  assign w_irq_rd = {{(AVS_DATA_W-2){1'b0}}, r_irq_done, r_irq_ie};
  assign w_unused = ^avs.wrdata[AVS_DATA_W-1:8];
`else
  assign o_irq    = 1'b0;
  assign w_irq_rd = '0;
  assign w_unused = ^{avs.wrdata[AVS_DATA_W-1:8], i_core_done, w_wr_irq};
`endif

  always_comb begin
    w_status                            = '0;
    w_status[ST_BUSY]                   = r_cmd_valid | i_core_busy;
    w_status[ST_RNB]                    = w_rnb;
    w_status[ST_RX_EMPTY]               = w_rx_empty;
    w_status[ST_RX_FULL]                = w_rx_full;
    w_status[ST_RX_OVF]                 = r_rx_ovf;
    w_status[ST_RX_UNF]                 = r_rx_unf;
    w_status[ST_CMD_REJ]                = r_cmd_rej;
    w_status[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(w_rx_count);
  end

  // rddata tracks addr every cycle; the host sets addr a cycle ahead of rd.
  always_comb begin
    w_rd_mux = '0;
    case (avs.addr)
      REG_DATA:   w_rd_mux[7:0]  = w_rx_head;
      REG_CMD:    w_rd_mux[7:0]  = r_cmd_code;
      REG_STATUS: w_rd_mux[15:0] = w_status;
      REG_IRQ:    w_rd_mux       = w_irq_rd;
      default:    w_rd_mux       = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rddata <= '0;
    else          r_rddata <= w_rd_mux;
  end

  assign avs.rddata  = r_rddata;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_code  = r_cmd_code;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_nand_avalon_csr_slave.sv
// Directed plus randomized bench for nand_avalon_csr_slave against a queue-based register model.
module tb_nand_avalon_csr_slave;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_code;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       core_busy, core_done, nand_rnb, irq;

  nand_avalon_csr_slave_if bus ();

  nand_avalon_csr_slave #(.RX_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .avs         (bus.slave),
    .o_cmd_valid (cmd_valid),
    .o_cmd_code  (cmd_code),
    .i_cmd_ready (cmd_ready),
    .o_tx_valid  (tx_valid),
    .o_tx_data   (tx_data),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .i_core_busy (core_busy),
    .i_core_done (core_done),
    .i_nand_rnb  (nand_rnb),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: RX FIFO as a queue plus the visible register state.
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_rej = 1'b0;
  logic       m_cmd_valid = 1'b0;
  logic [7:0] m_cmd_code = 8'h00;
  logic       m_rnb = 1'b0;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = m_cmd_valid | core_busy;
    s[1]   = m_rnb;
    s[2]   = (m_q.size() == 0);
    s[3]   = (m_q.size() == DEPTH);
    s[4]   = m_ovf;
    s[5]   = m_unf;
    s[6]   = m_rej;
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a; bus.wrdata = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    @(negedge clk);
    bus.rd = 1'b1;
    d = bus.rddata;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // DATA read with an optional same-cycle core push; model applies pop first, then push.
  task automatic data_rd(input logic with_push, input logic [7:0] b, output logic [31:0] d,
                         output logic [31:0] exp);
    bus.addr = 2'd0;
    @(negedge clk);
    bus.rd = 1'b1; rx_valid = with_push; rx_data = b;
    d = bus.rddata;
    @(negedge clk);
    bus.rd = 1'b0; rx_valid = 1'b0;
    if (m_q.size() > 0) begin
      exp = {24'h0, m_q.pop_front()};
    end else begin
      exp = 32'h0;
      m_unf = 1'b1;
    end
    if (with_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    rd_reg(2'd2, d);
    chk(tag, d, exp_status());
  endtask

  initial begin
    logic [31:0] d, e;
    logic [7:0]  b;
    logic [7:0]  read_id [5];
    read_id = '{8'h2C, 8'h68, 8'h00, 8'h27, 8'hA9};

    rst_n = 1'b0;
    bus.addr = 2'd0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wrdata = '0;
    cmd_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    core_busy = 1'b0; core_done = 1'b0; nand_rnb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_rddata", bus.rddata, 32'h0);
    chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk_status("rst_status");

    // Command handshake and rejection
    wr_reg(2'd1, 32'h09);
    m_cmd_valid = 1'b1; m_cmd_code = 8'h09;
    chk("cmd_valid_set", {31'h0, cmd_valid}, 32'h1);
    chk("cmd_code_set", {24'h0, cmd_code}, 32'h09);
    chk_status("status_busy");
    rd_reg(2'd1, d);
    chk("cmd_readback", d, {24'h0, m_cmd_code});
    wr_reg(2'd1, 32'h01);
    m_rej = 1'b1;
    chk("cmd_code_kept", {24'h0, cmd_code}, 32'h09);
    chk_status("status_rej");
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0; m_cmd_valid = 1'b0;
    chk("cmd_accept", {31'h0, cmd_valid}, 32'h0);
    wr_reg(2'd2, 32'h40);
    m_rej = 1'b0;
    chk_status("status_rej_w1c");
    core_busy = 1'b1;
    chk_status("status_core_busy");
    core_busy = 1'b0;

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 8'h19));
      wr_reg(2'd1, {24'h0, b});
      chk("rnd_cmd_code", {24'h0, cmd_code}, {24'h0, b});
      // write arriving on the acceptance edge is refused
      bus.addr = 2'd1; bus.wrdata = {24'h0, ~b}; bus.wr = 1'b1; cmd_ready = 1'b1;
      @(negedge clk);
      bus.wr = 1'b0; cmd_ready = 1'b0;
      m_rej = 1'b1;
      chk("accept_vs_write", {23'h0, cmd_valid, cmd_code}, {24'h0, b});
      chk_status("accept_vs_write_rej");
      wr_reg(2'd2, 32'h40);
      m_rej = 1'b0;
    end

    // READ_ID bytes through the RX FIFO, then underflow
    for (int i = 0; i < 5; i++) push(read_id[i]);
    chk_status("status_count5");
    for (int i = 0; i < 6; i++) begin
      data_rd(1'b0, 8'h00, d, e);
      chk("read_id_byte", d, e);
    end
    chk_status("status_underflow");
    wr_reg(2'd2, 32'h20);
    m_unf = 1'b0;

    // Overflow at full, push+pop at full, set-vs-clear
    for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
    chk_status("status_full_ovf");
    data_rd(1'b1, 8'h5A, d, e);
    chk("full_pushpop_data", d, e);
    chk_status("full_pushpop_count");
    rx_valid = 1'b1; rx_data = 8'hEE;
    wr_reg(2'd2, 32'h10);
    rx_valid = 1'b0;
    chk_status("ovf_set_wins");
    wr_reg(2'd2, 32'h10);
    m_ovf = 1'b0;
    chk_status("ovf_cleared");
    for (int i = 0; i < DEPTH; i++) begin
      data_rd(1'b0, 8'h00, d, e);
      chk("drain_byte", d, e);
    end
    chk_status("drained");

    // RnB synchronizer latency and TX pulse
    bus.addr = 2'd2;
    @(negedge clk);
    nand_rnb = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("rnb_not_yet", {31'h0, bus.rddata[1]}, 32'h0);
    @(negedge clk);
    chk("rnb_synced", {31'h0, bus.rddata[1]}, 32'h1);
    m_rnb = 1'b1;
    wr_reg(2'd0, 32'hFFFF_FFA5);
    chk("tx_pulse", {23'h0, tx_valid, tx_data}, 32'h1A5);
    @(negedge clk);
    chk("tx_pulse_end", {31'h0, tx_valid}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: push(8'($urandom));
        1: begin data_rd(1'b0, 8'h00, d, e); chk("rnd_read", d, e); end
        2: begin data_rd(1'b1, 8'($urandom), d, e); chk("rnd_pushpop", d, e); end
        default: begin
          b = 8'($urandom_range(0, 7) << 4);
          wr_reg(2'd2, {24'h0, b});
          if (b[4]) m_ovf = 1'b0;
          if (b[5]) m_unf = 1'b0;
          if (b[6]) m_rej = 1'b0;
        end
      endcase
      chk_status("rnd_status");
    end

    // Interrupt register
`ifdef NAND_CSR_IRQ_EN
    wr_reg(2'd3, 32'h1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_reg(2'd3, d);
    chk("irq_reg", d, 32'h3);
    wr_reg(2'd3, 32'h3);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    core_done = 1'b1;
    wr_reg(2'd3, 32'h3);
    core_done = 1'b0;
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    wr_reg(2'd3, 32'h2);
    rd_reg(2'd3, d);
    chk("irq_reg_off", d, 32'h0);
`else
    wr_reg(2'd3, 32'h1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("irq_disabled", {31'h0, irq}, 32'h0);
    rd_reg(2'd3, d);
    chk("irq_reg_disabled", d, 32'h0);
`endif

    // Reset mid-command
    nand_rnb = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    m_rnb = 1'b0;
    wr_reg(2'd1, 32'h05);
    chk("pre_rst_cmd", {31'h0, cmd_valid}, 32'h1);
    push(8'h11); push(8'h22);
    bus.addr = 2'd2;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    chk("rst_mid_rddata", bus.rddata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete(); m_cmd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_rej = 1'b0;
    chk_status("post_rst_status");
    rd_reg(2'd1, d);
    chk("post_rst_cmd_code", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
